// File: rtl/excpt_scheduler.sv
// CP0-style exception scheduler: owns Count/Compare/Status/Cause/EPC and issues a
// single registered excptype code (timer, syscall, eret) to the exception controller.
module excpt_scheduler #(
    parameter int          TIMER_ENABLE       = 1,
    parameter logic [31:0] SYSCALL_EPC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] pc_i,
    input  logic        syscall_req,
    input  logic        eret_req,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] excptype,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_STATUS  = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;

    localparam logic [31:0] EXC_TIMER   = 32'h0000_0004;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
    localparam logic [31:0] EXC_ERET    = 32'h0000_0200;

    state_t      state_reg, state_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] excptype_reg, excptype_next;
    logic [4:0]  exccode_reg, exccode_next;
    logic        ie_reg, ie_next;
    logic        im2_reg, im2_next;
    logic        ip2_reg, ip2_next;

    logic accept;
    logic take_timer;
    logic take_sys;
    logic take_eret;
    logic take_any;
    logic timer_hit;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    // Requests are only looked at outside the one-cycle flush after an issued code.
    assign accept     = inst_valid && (excptype_reg == 32'd0);
    assign take_timer = accept && (state_reg == RUN) && ie_reg && im2_reg && ip2_reg;
    assign take_sys   = accept && (state_reg == RUN) && !take_timer && syscall_req;
    assign take_eret  = accept && (state_reg == HANDLER) && eret_req;
    assign take_any   = take_timer || take_sys || take_eret;
    assign timer_hit  = (TIMER_ENABLE != 0) && (compare_reg != 32'd0) && (count_reg == compare_reg);

    assign wr_count   = cp0_we && (cp0_waddr == REG_COUNT);
    assign wr_compare = cp0_we && (cp0_waddr == REG_COMPARE);
    assign wr_status  = cp0_we && (cp0_waddr == REG_STATUS);
    assign wr_cause   = cp0_we && (cp0_waddr == REG_CAUSE);
    assign wr_epc     = cp0_we && (cp0_waddr == REG_EPC);

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg + 32'd1;
        compare_next  = compare_reg;
        epc_next      = epc_reg;
        excptype_next = 32'd0;
        exccode_next  = exccode_reg;
        ie_next       = ie_reg;
        im2_next      = im2_reg;
        ip2_next      = ip2_reg || timer_hit;

        if (wr_count) begin
            count_next = cp0_wdata;
        end
        // A Compare write acknowledges the timer even if it would have fired this cycle.
        if (wr_compare) begin
            compare_next = cp0_wdata;
            ip2_next     = 1'b0;
        end

        // Software writes to Status/Cause/EPC lose against an accepted exception or eret.
        if (!take_any) begin
            if (wr_status) begin
                ie_next    = cp0_wdata[0];
                state_next = state_t'(cp0_wdata[1]);
                im2_next   = cp0_wdata[10];
            end
            if (wr_cause) begin
                exccode_next = cp0_wdata[6:2];
            end
            if (wr_epc) begin
                epc_next = cp0_wdata;
            end
        end

        if (take_timer) begin
            excptype_next = EXC_TIMER;
            epc_next      = pc_i;
            exccode_next  = 5'd0;
            state_next    = HANDLER;
        end else if (take_sys) begin
            excptype_next = EXC_SYSCALL;
            epc_next      = pc_i + SYSCALL_EPC_OFFSET;
            exccode_next  = 5'd8;
            state_next    = HANDLER;
        end else if (take_eret) begin
            excptype_next = EXC_ERET;
            state_next    = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            count_reg    <= 32'd0;
            compare_reg  <= 32'd0;
            epc_reg      <= 32'd0;
            excptype_reg <= 32'd0;
            exccode_reg  <= 5'd0;
            ie_reg       <= 1'b0;
            im2_reg      <= 1'b0;
            ip2_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            compare_reg  <= compare_next;
            epc_reg      <= epc_next;
            excptype_reg <= excptype_next;
            exccode_reg  <= exccode_next;
            ie_reg       <= ie_next;
            im2_reg      <= im2_next;
            ip2_reg      <= ip2_next;
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            REG_COUNT:   cp0_rdata = count_reg;
            REG_COMPARE: cp0_rdata = compare_reg;
            REG_STATUS:  cp0_rdata = {21'd0, im2_reg, 8'd0, (state_reg == HANDLER), ie_reg};
            REG_CAUSE:   cp0_rdata = {21'd0, ip2_reg, 3'd0, exccode_reg, 2'd0};
            REG_EPC:     cp0_rdata = epc_reg;
            default:     cp0_rdata = 32'd0;
        endcase
    end

    assign excptype    = excptype_reg;
    assign epc_o       = epc_reg;
    assign timer_int_o = ip2_reg;

endmodule
